pipe_hazard_ctrl: RTL and testbench

- Central stall/flush controller for the 5-stage core.
- Produces the FORWARD_stall*/FORWARD_flush* controls consumed by the IF/ID, ID/EX, EX/MEM and MEM/WB segment registers, including FORWARD_flushME and FORWARD_stallWB.
- Tracks outstanding data-memory accesses, load-use hazards, EX-stage branch redirects (held while fetch is busy) and system halt.
- Sits beside the pipeline, purely as a control source.

---
 rtl/pipe_hazard_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: central stall/flush controller for the 5-stage core.
// Drives the hold (stall*) and bubble (flush*) controls of the IF/ID, ID/EX,
// EX/MEM and MEM/WB segment registers. It tracks outstanding data-memory
// accesses, load-use hazards, EX-stage branch redirects (deferred while fetch
// is busy) and system halt. It does not touch the datapath.
//
// Optional build macro: PIPE_HAZARD_PERF_EN adds four CNT_W-bit wrapping
// performance counters (dmem wait cycles, load-use bubbles, redirect cycles,
// fetch stall cycles). Counting stops while halted.
module pipe_hazard_ctrl #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      ID_rs1,
  input  logic [4:0]      ID_rs2,
  input  logic            ID_use_rs1,
  input  logic            ID_use_rs2,
  input  logic [4:0]      EX_rd,
  input  logic            EX_mem_to_reg,
  input  logic            EX_branch_taken,
  input  logic [XLEN-1:0] EX_branch_target,
  input  logic            IF_busy,
  input  logic            MEM_req_valid,
  input  logic            MEM_resp_valid,
  input  logic            WB_i_commit,
  input  logic            WB_i_system_halt,
  output logic            FORWARD_stallIF,
  output logic            FORWARD_stallID,
  output logic            FORWARD_stallEX,
  output logic            FORWARD_stallME,
  output logic            FORWARD_stallWB,
  output logic            FORWARD_flushIF,
  output logic            FORWARD_flushID,
  output logic            FORWARD_flushEX,
  output logic            FORWARD_flushME,
  output logic            IF_redirect_valid,
  output logic [XLEN-1:0] IF_redirect_pc,
  output logic            halted
`ifdef PIPE_HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0] perf_dwait_cyc,
  output logic [CNT_W-1:0] perf_loaduse_cnt,
  output logic [CNT_W-1:0] perf_redirect_cnt,
  output logic [CNT_W-1:0] perf_fetch_stall_cyc
`endif
);

  // Legacy-compatible state encoding.
  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_DWAIT  = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  // Segment-register control bundle, one bit per hold/bubble line.
  typedef struct packed {
    logic stall_if;
    logic stall_id;
    logic stall_ex;
    logic stall_me;
    logic stall_wb;
    logic flush_if;
    logic flush_id;
    logic flush_ex;
    logic flush_me;
  } ctrl_t;

  logic [1:0]      state, state_nxt;
  logic            pend_valid, pend_valid_nxt;
  logic [XLEN-1:0] pend_pc, pend_pc_nxt;

  ctrl_t           ctrl;
  logic            redir_vld;
  logic [XLEN-1:0] redir_pc;
  logic            halted_q;

  // Which rule actually owned this cycle (feeds the optional counters).
  logic            fire_dmem, fire_lu, fire_redir, fire_fetch;

  logic            load_use, dmem_stall, redirect, halt_commit;

  // Hazard detection terms. x0 is never a real producer, so EX_rd==0 is no hazard.
  assign load_use    = EX_mem_to_reg && (EX_rd != 5'd0) &&
                       ((ID_use_rs1 && (ID_rs1 == EX_rd)) ||
                        (ID_use_rs2 && (ID_rs2 == EX_rd)));
  assign dmem_stall  = ((state == ST_DWAIT) || ((state == ST_RUN) && MEM_req_valid)) &&
                       !MEM_resp_valid;
  assign redirect    = EX_branch_taken || pend_valid;
  assign halt_commit = WB_i_commit && WB_i_system_halt;

  // Output decode: prioritised rules, all combinational from state and inputs.
  always_comb begin
    ctrl       = '0;
    redir_vld  = 1'b0;
    redir_pc   = '0;
    halted_q   = 1'b0;
    fire_dmem  = 1'b0;
    fire_lu    = 1'b0;
    fire_redir = 1'b0;
    fire_fetch = 1'b0;
    if (rst) begin
      // Everything quiet while reset is held.
    end else if (state == ST_HALTED) begin
      // Freeze the whole pipe, including WB so nothing further commits.
      ctrl.stall_if = 1'b1;
      ctrl.stall_id = 1'b1;
      ctrl.stall_ex = 1'b1;
      ctrl.stall_me = 1'b1;
      ctrl.stall_wb = 1'b1;
      halted_q      = 1'b1;
    end else if (dmem_stall) begin
      // Hold IF..MEM, drain a bubble into MEM/WB so WB keeps retiring.
      // A branch in EX is held too and re-presents once the access completes.
      ctrl.stall_if = 1'b1;
      ctrl.stall_id = 1'b1;
      ctrl.stall_ex = 1'b1;
      ctrl.stall_me = 1'b1;
      ctrl.flush_me = 1'b1;
      fire_dmem     = 1'b1;
    end else if (redirect) begin
      // Wrong-path squash. Only the real branch cycle has a wrong-path
      // instruction in ID/EX; on pending cycles EX already holds a bubble,
      // and a branch reported there is ignored.
      fire_redir    = 1'b1;
      ctrl.flush_id = 1'b1;
      ctrl.flush_ex = EX_branch_taken && !pend_valid;
      if (IF_busy) begin
        ctrl.stall_if = 1'b1;
      end else begin
        redir_vld = 1'b1;
        redir_pc  = pend_valid ? pend_pc : EX_branch_target;
      end
    end else begin
      // Load-use and fetch-busy combine; holding ID beats bubbling it.
      if (load_use) begin
        ctrl.stall_if = 1'b1;
        ctrl.stall_id = 1'b1;
        ctrl.flush_ex = 1'b1;
        fire_lu       = 1'b1;
      end
      if (IF_busy) begin
        ctrl.stall_if = 1'b1;
        fire_fetch    = 1'b1;
      end
      ctrl.flush_id = IF_busy && !load_use;
    end
  end

  assign FORWARD_stallIF   = ctrl.stall_if;
  assign FORWARD_stallID   = ctrl.stall_id;
  assign FORWARD_stallEX   = ctrl.stall_ex;
  assign FORWARD_stallME   = ctrl.stall_me;
  assign FORWARD_stallWB   = ctrl.stall_wb;
  assign FORWARD_flushIF   = ctrl.flush_if;
  assign FORWARD_flushID   = ctrl.flush_id;
  assign FORWARD_flushEX   = ctrl.flush_ex;
  assign FORWARD_flushME   = ctrl.flush_me;
  assign IF_redirect_valid = redir_vld;
  assign IF_redirect_pc    = redir_pc;
  assign halted            = halted_q;

  // Next-state: dmem wait tracking, deferred redirect capture, halt entry.
  always_comb begin
    state_nxt      = state;
    pend_valid_nxt = pend_valid;
    pend_pc_nxt    = pend_pc;
    if (state != ST_HALTED) begin
      state_nxt = dmem_stall ? ST_DWAIT : ST_RUN;
      // Redirect bookkeeping only advances when the pipe is moving.
      if (!dmem_stall && redirect) begin
        if (IF_busy) begin
          pend_valid_nxt = 1'b1;
          if (!pend_valid) pend_pc_nxt = EX_branch_target;
        end else begin
          pend_valid_nxt = 1'b0;
        end
      end
      if (halt_commit) state_nxt = ST_HALTED;
    end
  end

  // Controller state registers; reset drops any wait or pending redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_RUN;
      pend_valid <= 1'b0;
      pend_pc    <= '0;
    end else begin
      state      <= state_nxt;
      pend_valid <= pend_valid_nxt;
      pend_pc    <= pend_pc_nxt;
    end
  end

`ifdef PIPE_HAZARD_PERF_EN
  // Event counters; fire_* are already gated off in reset and HALTED.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_dwait_cyc       <= '0;
      perf_loaduse_cnt     <= '0;
      perf_redirect_cnt    <= '0;
      perf_fetch_stall_cyc <= '0;
    end else begin
      if (fire_dmem)  perf_dwait_cyc       <= perf_dwait_cyc + 1'b1;
      if (fire_lu)    perf_loaduse_cnt     <= perf_loaduse_cnt + 1'b1;
      if (fire_redir) perf_redirect_cnt    <= perf_redirect_cnt + 1'b1;
      if (fire_fetch) perf_fetch_stall_cyc <= perf_fetch_stall_cyc + 1'b1;
    end
  end
`else
  // Counter width only matters when the counters exist.
  logic unused_perf;
  assign unused_perf = (CNT_W == 0) ^ fire_dmem ^ fire_lu ^ fire_redir ^ fire_fetch;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl: directed scenarios followed by random
// traffic, all checked cycle by cycle against a behavioural model.
module tb_pipe_hazard_ctrl;
  localparam int XLEN  = 32;
  localparam int CNT_W = 32;

  // {stallIF,ID,EX,ME,WB, flushIF,ID,EX,ME, redirect_valid, halted}
  localparam logic [10:0] V_IDLE  = 11'b00000_0000_00;
  localparam logic [10:0] V_DSTL  = 11'b11110_0001_00;
  localparam logic [10:0] V_HALT  = 11'b11111_0000_01;
  localparam logic [10:0] V_BRIDL = 11'b00000_0110_10;
  localparam logic [10:0] V_LU    = 11'b11000_0010_00;
  localparam logic [10:0] V_PEND  = 11'b10000_0100_00;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] ID_rs1, ID_rs2, EX_rd;
  logic ID_use_rs1, ID_use_rs2, EX_mem_to_reg, EX_branch_taken;
  logic [XLEN-1:0] EX_branch_target;
  logic IF_busy, MEM_req_valid, MEM_resp_valid, WB_i_commit, WB_i_system_halt;
  logic FORWARD_stallIF, FORWARD_stallID, FORWARD_stallEX, FORWARD_stallME, FORWARD_stallWB;
  logic FORWARD_flushIF, FORWARD_flushID, FORWARD_flushEX, FORWARD_flushME;
  logic IF_redirect_valid;
  logic [XLEN-1:0] IF_redirect_pc;
  logic halted;
`ifdef PIPE_HAZARD_PERF_EN
  logic [CNT_W-1:0] perf_dwait_cyc, perf_loaduse_cnt, perf_redirect_cnt, perf_fetch_stall_cyc;
  logic [CNT_W-1:0] m_cnt [4];
`endif

  pipe_hazard_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .ID_rs1(ID_rs1), .ID_rs2(ID_rs2), .ID_use_rs1(ID_use_rs1), .ID_use_rs2(ID_use_rs2),
    .EX_rd(EX_rd), .EX_mem_to_reg(EX_mem_to_reg), .EX_branch_taken(EX_branch_taken),
    .EX_branch_target(EX_branch_target), .IF_busy(IF_busy),
    .MEM_req_valid(MEM_req_valid), .MEM_resp_valid(MEM_resp_valid),
    .WB_i_commit(WB_i_commit), .WB_i_system_halt(WB_i_system_halt),
    .FORWARD_stallIF(FORWARD_stallIF), .FORWARD_stallID(FORWARD_stallID),
    .FORWARD_stallEX(FORWARD_stallEX), .FORWARD_stallME(FORWARD_stallME),
    .FORWARD_stallWB(FORWARD_stallWB), .FORWARD_flushIF(FORWARD_flushIF),
    .FORWARD_flushID(FORWARD_flushID), .FORWARD_flushEX(FORWARD_flushEX),
    .FORWARD_flushME(FORWARD_flushME), .IF_redirect_valid(IF_redirect_valid),
    .IF_redirect_pc(IF_redirect_pc), .halted(halted)
`ifdef PIPE_HAZARD_PERF_EN
    , .perf_dwait_cyc(perf_dwait_cyc), .perf_loaduse_cnt(perf_loaduse_cnt),
    .perf_redirect_cnt(perf_redirect_cnt), .perf_fetch_stall_cyc(perf_fetch_stall_cyc)
`endif
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [10:0] dut_vec();
    return {FORWARD_stallIF, FORWARD_stallID, FORWARD_stallEX, FORWARD_stallME,
            FORWARD_stallWB, FORWARD_flushIF, FORWARD_flushID, FORWARD_flushEX,
            FORWARD_flushME, IF_redirect_valid, halted};
  endfunction

  // Reference model: the core is either frozen, waiting on data memory,
  // carrying a remembered redirect, or running freely.
  bit              m_halt, m_dwait, m_pend;
  logic [XLEN-1:0] m_pend_pc;
  logic [10:0]     e_vec;
  logic [XLEN-1:0] e_pc;
  logic [3:0]      e_fire;   // {fetch, redirect, loaduse, dmem}

  function automatic void model_eval();
    bit hit, s_if, s_id, f_id, f_ex, rv;
    e_vec = V_IDLE; e_pc = '0; e_fire = '0;
    if (rst) return;
    if (m_halt) begin e_vec = V_HALT; return; end
    if ((m_dwait || MEM_req_valid) && !MEM_resp_valid) begin
      e_vec = V_DSTL; e_fire[0] = 1'b1; return;
    end
    s_if = 0; s_id = 0; f_id = 0; f_ex = 0; rv = 0;
    if (EX_branch_taken || m_pend) begin
      e_fire[2] = 1'b1;
      f_id = 1;
      f_ex = !m_pend;
      if (IF_busy) s_if = 1;
      else begin rv = 1; e_pc = m_pend ? m_pend_pc : EX_branch_target; end
    end else begin
      hit = EX_mem_to_reg && EX_rd != 0 &&
            ((ID_use_rs1 && ID_rs1 == EX_rd) || (ID_use_rs2 && ID_rs2 == EX_rd));
      if (hit) begin s_if = 1; s_id = 1; f_ex = 1; e_fire[1] = 1'b1; end
      if (IF_busy) begin s_if = 1; e_fire[3] = 1'b1; if (!hit) f_id = 1; end
    end
    e_vec = {s_if, s_id, 3'b000, 1'b0, f_id, f_ex, 1'b0, rv, 1'b0};
  endfunction

  function automatic void model_step();
    if (rst) begin
      m_halt = 0; m_dwait = 0; m_pend = 0;
`ifdef PIPE_HAZARD_PERF_EN
      for (int k = 0; k < 4; k++) m_cnt[k] = '0;
`endif
      return;
    end
    if (m_halt) return;
`ifdef PIPE_HAZARD_PERF_EN
    for (int k = 0; k < 4; k++) if (e_fire[k]) m_cnt[k] = m_cnt[k] + 1;
`endif
    if (!e_fire[0] && (EX_branch_taken || m_pend)) begin
      if (IF_busy) begin
        if (!m_pend) m_pend_pc = EX_branch_target;
        m_pend = 1;
      end else m_pend = 0;
    end
    m_dwait = e_fire[0];
    if (WB_i_commit && WB_i_system_halt) m_halt = 1;
  endfunction

  // Settle, compare against the model; caller may add explicit checks after.
  task automatic settle_check(input string tag);
    #2;
    model_eval();
    chk({tag, "_ctrl"}, 64'(dut_vec()), 64'(e_vec));
    chk({tag, "_pc"}, 64'(IF_redirect_pc), 64'(e_pc));
`ifdef PIPE_HAZARD_PERF_EN
    chk({tag, "_pdw"}, 64'(perf_dwait_cyc), 64'(m_cnt[0]));
    chk({tag, "_plu"}, 64'(perf_loaduse_cnt), 64'(m_cnt[1]));
    chk({tag, "_prd"}, 64'(perf_redirect_cnt), 64'(m_cnt[2]));
    chk({tag, "_pfs"}, 64'(perf_fetch_stall_cyc), 64'(m_cnt[3]));
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_in();
    rst = 0; ID_rs1 = 0; ID_rs2 = 0; ID_use_rs1 = 0; ID_use_rs2 = 0; EX_rd = 0;
    EX_mem_to_reg = 0; EX_branch_taken = 0; EX_branch_target = '0; IF_busy = 0;
    MEM_req_valid = 0; MEM_resp_valid = 0; WB_i_commit = 0; WB_i_system_halt = 0;
  endtask

  initial begin
    m_halt = 0; m_dwait = 0; m_pend = 0; m_pend_pc = '0;
`ifdef PIPE_HAZARD_PERF_EN
    for (int k = 0; k < 4; k++) m_cnt[k] = '0;
`endif
    // Reset with every input asserted.
    idle_in();
    rst = 1; ID_rs1 = 5'd7; ID_rs2 = 5'd7; ID_use_rs1 = 1; ID_use_rs2 = 1; EX_rd = 5'd7;
    EX_mem_to_reg = 1; EX_branch_taken = 1; EX_branch_target = '1; IF_busy = 1;
    MEM_req_valid = 1; MEM_resp_valid = 1; WB_i_commit = 1; WB_i_system_halt = 1;
    for (int i = 0; i < 2; i++) begin
      settle_check("rst_all");
      chk("rst_zero", 64'(dut_vec()), 64'(V_IDLE));
      tick();
    end
    idle_in();
    settle_check("post_rst");
    chk("post_rst_zero", 64'(dut_vec()), 64'(V_IDLE));
    tick();

    // Dmem stall: 3 stall cycles, then response.
    MEM_req_valid = 1;
    for (int i = 0; i < 3; i++) begin
      settle_check("dstall");
      chk("dstall_vec", 64'(dut_vec()), 64'(V_DSTL));
      tick();
      MEM_req_valid = 0;
    end
    MEM_resp_valid = 1;
    settle_check("dresp");
    chk("dresp_vec", 64'(dut_vec()), 64'(V_IDLE));
    tick();
    idle_in();

    // Load-use, then the x0 case.
    EX_mem_to_reg = 1; EX_rd = 5'd5; ID_rs2 = 5'd5; ID_use_rs2 = 1;
    settle_check("lu");
    chk("lu_vec", 64'(dut_vec()), 64'(V_LU));
    tick();
    EX_rd = 5'd0; ID_rs2 = 5'd0;
    settle_check("lu_x0");
    chk("lu_x0_vec", 64'(dut_vec()), 64'(V_IDLE));
    tick();
    idle_in();

    // Branch with fetch idle.
    EX_branch_taken = 1; EX_branch_target = 32'h8000_0010;
    settle_check("br");
    chk("br_vec", 64'(dut_vec()), 64'(V_BRIDL));
    chk("br_pc", 64'(IF_redirect_pc), 64'h8000_0010);
    tick();
    idle_in();
    settle_check("br_after");
    tick();

    // Branch while fetch busy, then 2 more busy cycles.
    EX_branch_taken = 1; EX_branch_target = 32'h8000_0020; IF_busy = 1;
    settle_check("pend0");
    tick();
    EX_branch_taken = 0; EX_branch_target = 32'h1234_5678;
    for (int i = 0; i < 2; i++) begin
      settle_check("pend");
      chk("pend_vec", 64'(dut_vec()), 64'(V_PEND));
      tick();
    end
    IF_busy = 0;
    settle_check("pend_go");
    chk("pend_go_rv", 64'(IF_redirect_valid), 64'd1);
    chk("pend_go_pc", 64'(IF_redirect_pc), 64'h8000_0020);
    tick();
    settle_check("pend_done");
    chk("pend_done_rv", 64'(IF_redirect_valid), 64'd0);
    tick();

    // Halt committed during DWAIT.
    MEM_req_valid = 1;
    settle_check("h_req");
    tick();
    MEM_req_valid = 0; WB_i_commit = 1; WB_i_system_halt = 1;
    settle_check("h_commit");
    tick();
    WB_i_commit = 0; WB_i_system_halt = 0; MEM_resp_valid = 1;
    for (int i = 0; i < 2; i++) begin
      settle_check("halted");
      chk("halted_vec", 64'(dut_vec()), 64'(V_HALT));
      tick();
    end
    rst = 1;
    settle_check("h_rst");
    tick();
    idle_in();
    settle_check("h_run");
    chk("h_run_vec", 64'(dut_vec()), 64'(V_IDLE));
    tick();

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      rst              = m_halt ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 149) == 0);
      ID_rs1           = 5'($urandom_range(0, 3));
      ID_rs2           = 5'($urandom_range(0, 3));
      EX_rd            = 5'($urandom_range(0, 3));
      ID_use_rs1       = 1'($urandom_range(0, 1));
      ID_use_rs2       = 1'($urandom_range(0, 1));
      EX_mem_to_reg    = 1'($urandom_range(0, 1));
      EX_branch_taken  = ($urandom_range(0, 4) == 0);
      EX_branch_target = $urandom;
      IF_busy          = ($urandom_range(0, 2) == 0);
      MEM_req_valid    = ($urandom_range(0, 3) == 0);
      MEM_resp_valid   = ($urandom_range(0, 2) == 0);
      WB_i_commit      = 1'($urandom_range(0, 1));
      WB_i_system_halt = ($urandom_range(0, 59) == 0);
      settle_check("rnd");
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
